// File: rtl/bcd_arbiter.sv
// bcd_arbiter: four-channel request arbiter feeding a shared binary-to-BCD converter.
// A grant captures the chosen channel's value. VAL_W double-dabble steps follow, then the result
// is presented for one cycle with done. Values above 9999 saturate to 16'h9999 and set ovf.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset
//   i_display_mode  0-3 gives that channel priority; 4 and above select pure round robin
//   i_req           per-channel conversion request
//   i_val_0..3      per-channel unsigned binary value
//   o_ack           one-hot grant/capture pulse (combinational, IDLE only)
//   o_busy          conversion in progress (SHIFT or DONE)
//   o_done          one-cycle result-valid pulse
//   o_done_chan     channel of the presented result
//   o_bcd           four BCD digits, thousands in [15:12]
//   o_ovf           captured value exceeded 9999
module bcd_arbiter #(
  parameter int unsigned VAL_W = 14
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_display_mode,
  input  logic [3:0]       i_req,
  input  logic [VAL_W-1:0] i_val_0,
  input  logic [VAL_W-1:0] i_val_1,
  input  logic [VAL_W-1:0] i_val_2,
  input  logic [VAL_W-1:0] i_val_3,
  output logic [3:0]       o_ack,
  output logic             o_busy,
  output logic             o_done,
  output logic [1:0]       o_done_chan,
  output logic [15:0]      o_bcd,
  output logic             o_ovf
);

  localparam int unsigned CntW = $clog2(VAL_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;

  logic [1:0]       r_last_grant;
  logic [1:0]       r_cap_chan;
  logic             r_cap_ovf;
  logic [VAL_W-1:0] r_val;
  logic [15:0]      r_shift;
  logic [CntW-1:0]  r_cnt;
  logic [1:0]       r_done_chan;
  logic [15:0]      r_bcd;
  logic             r_ovf;

  logic             w_grant_vld;
  logic [1:0]       w_grant_idx;
  logic [1:0]       w_cand;
  logic             w_found;
  logic [VAL_W-1:0] w_sel_val;
  logic             w_sel_ovf;
  logic [15:0]      w_adj;
  logic [15:0]      w_shift_next;
  logic [VAL_W-1:0] w_val_next;
  logic             w_last_step;

  // Arbitration: display-mode priority first, else round robin starting after last grant.
  always_comb begin
    w_grant_vld = |i_req;
    w_grant_idx = r_last_grant;
    w_cand      = r_last_grant;
    w_found     = 1'b0;
    if ((i_display_mode < 3'd4) && i_req[i_display_mode[1:0]]) begin
      w_grant_idx = i_display_mode[1:0];
    end else begin
      // Offset 4 wraps to the last grant itself, so a lone repeat requester is still served.
      for (int i = 1; i <= 4; i++) begin
        w_cand = r_last_grant + 2'(i);
        if (!w_found && i_req[w_cand]) begin
          w_grant_idx = w_cand;
          w_found     = 1'b1;
        end
      end
    end
  end

  always_comb begin
    unique case (w_grant_idx)
      2'd0:    w_sel_val = i_val_0;
      2'd1:    w_sel_val = i_val_1;
      2'd2:    w_sel_val = i_val_2;
      default: w_sel_val = i_val_3;
    endcase
    w_sel_ovf = 32'(w_sel_val) > 32'd9999;
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, value} left.
  always_comb begin
    w_adj = r_shift;
    for (int d = 0; d < 4; d++) begin
      if (r_shift[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_shift[4*d +: 4] + 4'd3;
      end
    end
    w_shift_next = 16'({w_adj, r_val[VAL_W-1]});
    w_val_next   = {r_val[VAL_W-2:0], 1'b0};
  end

  assign w_last_step = (r_cnt == CntW'(1));

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_vld) w_state_next = StShift;
      StShift: if (w_last_step) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs; ack and done are suppressed during reset so an aborted cycle shows nothing.
  always_comb begin
    o_ack  = 4'b0000;
    o_done = 1'b0;
    o_busy = (r_state != StIdle);
    unique case (r_state)
      StIdle:  if (w_grant_vld && !i_rst) o_ack[w_grant_idx] = 1'b1;
      StDone:  o_done = !i_rst;
      default: ;
    endcase
  end

  // Datapath: capture on grant, shift in SHIFT, publish the result on the last step.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_grant <= 2'd3;
      r_cap_chan   <= 2'd0;
      r_cap_ovf    <= 1'b0;
      r_val        <= '0;
      r_shift      <= 16'h0000;
      r_cnt        <= '0;
      r_done_chan  <= 2'd0;
      r_bcd        <= 16'h0000;
      r_ovf        <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_grant_vld) begin
            r_last_grant <= w_grant_idx;
            r_cap_chan   <= w_grant_idx;
            r_cap_ovf    <= w_sel_ovf;
            r_val        <= w_sel_val;
            r_shift      <= 16'h0000;
            r_cnt        <= CntW'(VAL_W);
          end
        end
        StShift: begin
          r_shift <= w_shift_next;
          r_val   <= w_val_next;
          r_cnt   <= r_cnt - CntW'(1);
          if (w_last_step) begin
            r_bcd       <= r_cap_ovf ? 16'h9999 : w_shift_next;
            r_ovf       <= r_cap_ovf;
            r_done_chan <= r_cap_chan;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_done_chan = r_done_chan;
  assign o_bcd       = r_bcd;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_bcd_arbiter.sv
// Self-checking bench for bcd_arbiter: table of single conversions, directed arbitration and
// reset sequences, then randomized traffic, all checked every cycle against a cycle-level model.
module tb_bcd_arbiter;

  localparam int VAL_W = 14;

  logic             clk;
  logic             rst;
  logic [2:0]       mode;
  logic [3:0]       req;
  logic [VAL_W-1:0] val [4];
  logic [3:0]       o_ack;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       o_done_chan;
  logic [15:0]      o_bcd;
  logic             o_ovf;

  bcd_arbiter #(.VAL_W(VAL_W)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_display_mode (mode),
    .i_req          (req),
    .i_val_0        (val[0]),
    .i_val_1        (val[1]),
    .i_val_2        (val[2]),
    .i_val_3        (val[3]),
    .o_ack          (o_ack),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_done_chan    (o_done_chan),
    .o_bcd          (o_bcd),
    .o_ovf          (o_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: phase 0 idle, 1..VAL_W shifting, VAL_W+1 presenting the result.
  int          m_p;
  int          m_last;
  int          m_cap;
  int          m_cap_ch;
  logic [15:0] m_bcd;
  logic        m_ovf;
  int          m_chan;

  // Observation log used to sequence the directed tests.
  int   ack_q[$];
  int   ack_cyc_q[$];
  bit   saw_ack;
  bit   saw_done;
  int   last_ack_ch;
  int   last_ack_cyc;
  int   last_done_cyc;

  typedef struct {
    int          ch;
    logic [2:0]  md;
    int          v;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int arb(input logic [3:0] r, input logic [2:0] m, input int last);
    if (m < 3'd4 && r[m[1:0]]) return int'(m);
    for (int i = 1; i <= 4; i++) begin
      int c;
      c = (last + i) % 4;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  function automatic logic [15:0] ref_bcd(input int v);
    if (v > 9999) return 16'h9999;
    return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16
              + (v % 10));
  endfunction

  function automatic int enc(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_p    = 0;
    m_last = 3;
    m_bcd  = 16'h0000;
    m_ovf  = 1'b0;
    m_chan = 0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int g;
    logic [3:0] e_ack;
    @(negedge clk);
    g     = arb(req, mode, m_last);
    e_ack = (m_p == 0 && !rst && req != 4'b0) ? 4'(1 << g) : 4'b0;
    check("ack", 32'(o_ack), 32'(e_ack));
    check("busy", 32'(o_busy), 32'(m_p != 0));
    check("done", 32'(o_done), 32'(m_p == VAL_W + 1 && !rst));
    check("bcd", 32'(o_bcd), 32'(m_bcd));
    check("ovf", 32'(o_ovf), 32'(m_ovf));
    check("done_chan", 32'(o_done_chan), 32'(m_chan));
    saw_ack  = (o_ack != 4'b0);
    saw_done = o_done;
    if (saw_ack) begin
      last_ack_ch  = enc(o_ack);
      last_ack_cyc = cyc;
      ack_q.push_back(last_ack_ch);
      ack_cyc_q.push_back(cyc);
    end
    if (saw_done) last_done_cyc = cyc;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (m_p == 0) begin
      if (req != 4'b0) begin
        m_last   = g;
        m_cap    = int'(val[g]);
        m_cap_ch = g;
        m_p      = 1;
      end
    end else if (m_p < VAL_W) begin
      m_p++;
    end else if (m_p == VAL_W) begin
      m_p    = VAL_W + 1;
      m_bcd  = ref_bcd(m_cap);
      m_ovf  = (m_cap > 9999);
      m_chan = m_cap_ch;
    end else begin
      m_p = 0;
    end
    #1;
    cyc++;
  endtask

  task automatic wait_ack(input string nm);
    saw_ack = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (saw_ack) break;
    end
    check(nm, 32'(saw_ack), 32'd1);
  endtask

  task automatic wait_done(input string nm);
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (saw_done) break;
    end
    check(nm, 32'(saw_done), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic convert(input int ch, input int v, input logic [2:0] md);
    val[ch] = VAL_W'(v);
    mode    = md;
    req     = 4'(1 << ch);
    wait_ack("conv_ack_timeout");
    req = 4'b0;
    wait_done("conv_done_timeout");
  endtask

  task automatic collect_acks(input int n, input string nm);
    for (int i = 0; i < 20 * n && ack_q.size() < n; i++) step();
    check(nm, 32'(ack_q.size()), 32'(n));
  endtask

  initial begin
    int exp_rr[5];
    int exp_pr[4];
    int n_iso;
    int n_done;

    tbl[0] = '{0, 3'd4, 1234,  16'h1234, 1'b0};
    tbl[1] = '{2, 3'd4, 16383, 16'h9999, 1'b1};
    tbl[2] = '{1, 3'd4, 9999,  16'h9999, 1'b0};
    tbl[3] = '{3, 3'd4, 10000, 16'h9999, 1'b1};
    tbl[4] = '{0, 3'd0, 0,     16'h0000, 1'b0};
    tbl[5] = '{2, 3'd2, 5,     16'h0005, 1'b0};
    tbl[6] = '{1, 3'd1, 9,     16'h0009, 1'b0};
    tbl[7] = '{3, 3'd3, 7890,  16'h7890, 1'b0};
    exp_rr = '{0, 1, 2, 3, 0};
    exp_pr = '{0, 2, 3, 0};

    rst  = 1'b1;
    mode = 3'd4;
    req  = 4'b0;
    for (int i = 0; i < 4; i++) val[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step();
    rst = 1'b0;
    check("reset_bcd", 32'(o_bcd), 32'h0);
    check("reset_busy", 32'(o_busy), 32'd0);

    // Table of single conversions.
    for (int k = 0; k < 8; k++) begin
      convert(tbl[k].ch, tbl[k].v, tbl[k].md);
      check("tbl_bcd", 32'(o_bcd), 32'(tbl[k].bcd));
      check("tbl_ovf", 32'(o_ovf), 32'(tbl[k].ovf));
      check("tbl_chan", 32'(o_done_chan), 32'(tbl[k].ch));
      check("tbl_latency", 32'(last_done_cyc - last_ack_cyc), 32'd15);
      step();
      check("tbl_hold_bcd", 32'(o_bcd), 32'(tbl[k].bcd));
    end

    // Round robin from reset with all requests held.
    do_reset();
    mode = 3'd4;
    req  = 4'hf;
    ack_q.delete();
    ack_cyc_q.delete();
    collect_acks(5, "rr_count");
    for (int i = 0; i < 5 && i < ack_q.size(); i++) check("rr_order", 32'(ack_q[i]), 32'(exp_rr[i]));
    for (int i = 0; i + 1 < ack_cyc_q.size(); i++)
      check("rr_spacing", 32'(ack_cyc_q[i+1] - ack_cyc_q[i]), 32'd16);
    req = 4'b0;
    repeat (20) step();

    // Priority: channel 3 wins repeatedly, then round robin skipping the non-requesting priority.
    do_reset();
    convert(0, 100, 3'd4);
    mode = 3'd3;
    req  = 4'hf;
    ack_q.delete();
    collect_acks(3, "prio_count");
    for (int i = 0; i < ack_q.size(); i++) check("prio_ch3", 32'(ack_q[i]), 32'd3);
    mode = 3'd1;
    req  = 4'b1101;
    ack_q.delete();
    collect_acks(4, "prio_rr_count");
    for (int i = 0; i < 4 && i < ack_q.size(); i++)
      check("prio_rr_order", 32'(ack_q[i]), 32'(exp_pr[i]));
    req = 4'b0;
    repeat (20) step();

    // Busy isolation: request and value churn during SHIFT must not disturb the conversion.
    val[0] = VAL_W'(42);
    mode   = 3'd4;
    req    = 4'b0001;
    wait_ack("iso_ack_timeout");
    n_iso = 0;
    for (int i = 0; i < 15; i++) begin
      req    = 4'($urandom);
      val[0] = VAL_W'($urandom);
      step();
      if (saw_ack) n_iso++;
    end
    check("iso_no_ack", 32'(n_iso), 32'd0);
    check("iso_done", 32'(saw_done), 32'd1);
    check("iso_bcd", 32'(o_bcd), 32'h0042);
    req = 4'b0;
    repeat (20) step();

    // Reset in the middle of a conversion.
    do_reset();
    convert(1, 5678, 3'd4);
    check("rstmid_pre_bcd", 32'(o_bcd), 32'h5678);
    val[2] = VAL_W'(3333);
    req    = 4'b0100;
    wait_ack("rstmid_ack_timeout");
    req = 4'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (saw_done) n_done++;
    end
    check("rstmid_no_done", 32'(n_done), 32'd0);
    check("rstmid_bcd", 32'(o_bcd), 32'h0);
    check("rstmid_chan", 32'(o_done_chan), 32'd0);
    check("rstmid_busy", 32'(o_busy), 32'd0);
    req = 4'hf;
    wait_ack("rstmid_regrant_timeout");
    check("rstmid_first_ch", 32'(last_ack_ch), 32'd0);
    req = 4'b0;
    repeat (20) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 127) == 0);
      mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 1) == 0) val[c] = VAL_W'($urandom_range(9990, 10010));
        else val[c] = VAL_W'($urandom);
      end
      step();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
